// File: rtl/rv32i_dmemarb.sv
// Data-port arbiter between the CPU memory stage and a loader/DMA requester.
// Bounds starvation on both sides and routes 1-cycle synchronous read returns.
module rv32i_dmemarb #(
  parameter int unsigned StarveLimit = 3,
  parameter int unsigned DmaBurst    = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_be_i,
  input  logic [29:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic        cpu_gnt_o,
  output logic        cpu_stall_o,
  output logic        cpu_rvalid_o,
  output logic [31:0] cpu_rdata_o,

  input  logic        dma_req_i,
  input  logic        dma_we_i,
  input  logic [3:0]  dma_be_i,
  input  logic [29:0] dma_addr_i,
  input  logic [31:0] dma_wdata_i,
  output logic        dma_gnt_o,
  output logic        dma_rvalid_o,
  output logic [31:0] dma_rdata_o,

  output logic        d_we_o,
  output logic [3:0]  d_be_o,
  output logic [29:0] d_addr_o,
  output logic [31:0] d_wdata_o,
  input  logic [31:0] d_rdata_i
);

  typedef enum logic [0:0] {StCpu, StDma} state_e;

  localparam logic [3:0] StarveMax = 4'(StarveLimit);
  localparam logic [3:0] BurstMax  = 4'(DmaBurst);

  state_e     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic [3:0] burst_q, burst_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_owner_q, rd_owner_d;
  logic       cpu_win, dma_win;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    burst_d  = burst_q;
    cpu_win  = 1'b0;
    dma_win  = 1'b0;
    unique case (state_q)
      StCpu: begin
        if (cpu_req_i && !(dma_req_i && (starve_q == StarveMax))) begin
          cpu_win = 1'b1;
          if (dma_req_i) begin
            starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 4'd1;
          end else begin
            starve_d = 4'd0;
          end
        end else if (dma_req_i) begin
          dma_win  = 1'b1;
          state_d  = StDma;
          burst_d  = 4'd1;
          starve_d = 4'd0;
        end else begin
          starve_d = 4'd0;
        end
      end
      StDma: begin
        if (dma_req_i && (!cpu_req_i || (burst_q < BurstMax))) begin
          dma_win = 1'b1;
          // Burst length only counts while the CPU is actually waiting.
          if (cpu_req_i && (burst_q < BurstMax)) begin
            burst_d = burst_q + 4'd1;
          end
        end else if (cpu_req_i) begin
          cpu_win  = 1'b1;
          state_d  = StCpu;
          burst_d  = 4'd0;
          starve_d = 4'd0;
        end else begin
          state_d = StCpu;
          burst_d = 4'd0;
        end
      end
    endcase
  end

  // Grants are suppressed while reset is held, even though they are combinational.
  assign cpu_gnt_o   = cpu_win & rst_ni;
  assign dma_gnt_o   = dma_win & rst_ni;
  assign cpu_stall_o = cpu_req_i & ~cpu_gnt_o;

  always_comb begin
    d_we_o    = 1'b0;
    d_be_o    = 4'h0;
    d_addr_o  = 30'd0;
    d_wdata_o = 32'd0;
    if (cpu_gnt_o) begin
      d_we_o    = cpu_we_i;
      d_be_o    = cpu_be_i;
      d_addr_o  = cpu_addr_i;
      d_wdata_o = cpu_wdata_i;
    end else if (dma_gnt_o) begin
      d_we_o    = dma_we_i;
      d_be_o    = dma_be_i;
      d_addr_o  = dma_addr_i;
      d_wdata_o = dma_wdata_i;
    end
  end

  always_comb begin
    rd_pend_d  = (cpu_gnt_o & ~cpu_we_i) | (dma_gnt_o & ~dma_we_i);
    rd_owner_d = rd_owner_q;
    if (cpu_gnt_o && !cpu_we_i) begin
      rd_owner_d = 1'b0;
    end else if (dma_gnt_o && !dma_we_i) begin
      rd_owner_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StCpu;
      starve_q   <= 4'd0;
      burst_q    <= 4'd0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      burst_q    <= burst_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign cpu_rvalid_o = rd_pend_q & ~rd_owner_q;
  assign dma_rvalid_o = rd_pend_q & rd_owner_q;
  assign cpu_rdata_o  = d_rdata_i;
  assign dma_rdata_o  = d_rdata_i;

endmodule

// File: doc/rv32i_dmemarb.md
Name: rv32i_dmemArb

Overview:
- Arbitrates the single data port of rv32i_syncDualPortRam between two requesters: the pipeline memory stage (CPU) and a program-loader/DMA requester.
- Sits between rv32i_memTop and the RAM d_* port.
- Drives a stall to the pipeline while the CPU waits for the port.
- Bounds starvation of each side with counters and routes synchronous read returns (1-cycle latency) back to the requester that issued them.

Parameters:
STARVE_LIMIT, 3, consecutive CPU grants with dma_req pending before DMA is forced a grant (1..15)
DMA_BURST, 4, max consecutive DMA grants while cpu_req is asserted (1..15)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset (0 = in reset)
cpu_req  input  1  CPU access request, held until cpu_gnt
cpu_we  input  1  CPU write (1) / read (0)
cpu_be  input  4  CPU byte enables
cpu_addr  input  30  CPU word address [31:2]
cpu_wdata  input  32  CPU write data
cpu_gnt  output  1  CPU access accepted this cycle
cpu_stall  output  1  cpu_req & !cpu_gnt
cpu_rvalid  output  1  CPU read data valid
cpu_rdata  output  32  CPU read data
dma_req, dma_we, dma_be, dma_addr, dma_wdata  input  1/1/4/30/32  DMA request bundle, same rules as CPU
dma_gnt  output  1  DMA access accepted this cycle
dma_rvalid  output  1  DMA read data valid
dma_rdata  output  32  DMA read data
d_we  output  1  to RAM write enable
d_be  output  4  to RAM byte enables
d_addr  output  30  to RAM word address
d_wdata  output  32  to RAM write data
d_rdata  input  32  from RAM read data (valid 1 cycle after address)

Behaviour:
- Reset (reset=0, async):
  - state=S_CPU; starve_cnt=0; burst_cnt=0; rd_pend=0; rd_owner=0.
  - cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid forced 0 while reset=0.
- Grants are combinational from the current requests and the registered state; at most one grant per cycle; a grant is never issued without its req.
- State S_CPU (CPU preferred):
  - cpu_req & !(dma_req & starve_cnt==STARVE_LIMIT): grant CPU.
    - If dma_req, starve_cnt++ (saturates at STARVE_LIMIT); else starve_cnt=0.
  - Else if dma_req: grant DMA; next state=S_DMA; burst_cnt=1; starve_cnt=0.
  - No request: no grant; starve_cnt=0.
- State S_DMA (burst in progress):
  - dma_req & (!cpu_req | burst_cnt<DMA_BURST): grant DMA.
    - burst_cnt++ only when cpu_req=1; saturates at DMA_BURST.
    - DMA holds the port indefinitely while the CPU is idle.
  - Else if cpu_req: grant CPU; next state=S_CPU; burst_cnt=0; starve_cnt=0.
  - No request: no grant; next state=S_CPU; burst_cnt=0.
- RAM port mux:
  - Granted requester's we/be/addr/wdata are driven onto d_*.
  - No grant: d_we=0, d_be=4'h0, d_addr=0, d_wdata=0.
  - d_we never asserts without a grant.
- Read return:
  - On a granted read (we=0), rd_pend<=1 and rd_owner<=requester (0=CPU, 1=DMA) at the next edge; otherwise rd_pend<=0.
  - cpu_rvalid = rd_pend & !rd_owner; dma_rvalid = rd_pend & rd_owner.
  - cpu_rdata = dma_rdata = d_rdata; only rvalid qualifies the data.
  - Back-to-back reads are supported: a new grant in the same cycle as an rvalid is legal.
- Writes produce no rvalid.
- Byte enables pass through unchanged; no width conversion is done here.
- Simultaneous first requests in S_CPU with starve_cnt<STARVE_LIMIT: CPU wins and dma_gnt=0.
- A request dropped before its grant is a protocol violation; the block only guarantees a consistent state (counters reset as in the no-request case).
- Reset asserted mid-read: rd_pend cleared; the pending rvalid is never produced.
- First cycle after reset release: S_CPU arbitration applies.

Test Plan:
- Reset: reset=0 with cpu_req=dma_req=1 -> both gnt=0, d_we=0, no rvalid. Release -> cpu_gnt=1 the same cycle.
- CPU-only read: cpu_req=1, cpu_we=0, cpu_addr=30'h10 -> cpu_gnt=1, d_addr=30'h10, cpu_stall=0. Next cycle cpu_rvalid=1 with cpu_rdata=RAM[0x40].
- Starvation (STARVE_LIMIT=3): cpu_req and dma_req held high -> CPU granted cycles 0-2, DMA granted cycle 3, cpu_stall=1 in cycle 3.
- Burst cap (DMA_BURST=4): DMA in S_DMA with both requests held -> exactly 4 consecutive dma_gnt, then cpu_gnt. With cpu_req=0 the DMA keeps the grant for 10+ cycles.
- Write routing: DMA write dma_be=4'b0011, dma_wdata=32'hDEADBEEF, addr 30'h5 -> d_we=1, d_be=4'b0011 in the grant cycle, no dma_rvalid. CPU read of addr 30'h5 -> low half 16'hBEEF.
- Read owner/reset: DMA read granted, then reset pulsed low before the next edge -> dma_rvalid stays 0. Alternating CPU/DMA reads -> each rvalid goes only to the issuing side.
